// File: rtl/cmp_serial.sv
// cmp_serial: digit-serial magnitude comparator with valid/ready handshakes.
// Ports: clk_i, rst_ni (async active-low), valid_i/ready_o request side,
//        a_i/b_i/signed_i operands, valid_o/ready_i result side,
//        gt_o/eq_o/lt_o/ge_o one-hot-ish result flags (0 while idle/busy).

// cmp_ge: combinational a_i >= b_i over WIDTH bits.
// Ports: a_i, b_i operands; ge_o result.
// SPEED=0 is a ripple chain; SPEED>=1 a log-depth (generate, equal) tree.
module cmp_ge #(
    parameter int WIDTH = 8,
    parameter int SPEED = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ge_o
);

    if (SPEED < 0 || SPEED > 2) begin : g_bad_speed
        $error("cmp_ge: SPEED must be 0, 1 or 2");
    end

    if (SPEED == 0) begin : g_serial
        always_comb begin
            ge_o = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                ge_o = (a_i[i] & ~b_i[i]) | (~(a_i[i] ^ b_i[i]) & ge_o);
            end
        end
    end else begin : g_tree
        // Only the root of the prefix network is needed for one GE output,
        // so Brent-Kung and Sklansky collapse to the same balanced tree.
        localparam int LVL = (WIDTH > 1) ? $clog2(WIDTH) : 1;
        localparam int P   = 1 << LVL;

        logic [P-1:0] g;
        logic [P-1:0] e;

        always_comb begin
            // Padding bits act as equal, so they never decide the result.
            g = '0;
            e = '1;
            g[WIDTH-1:0] = a_i & ~b_i;
            e[WIDTH-1:0] = ~(a_i ^ b_i);
            for (int l = 0; l < LVL; l++) begin
                for (int i = 0; i < P / 2; i++) begin
                    if (i < (P >> (l + 1))) begin
                        g[i] = g[2*i+1] | (e[2*i+1] & g[2*i]);
                        e[i] = e[2*i+1] & e[2*i];
                    end
                end
            end
            ge_o = g[0] | e[0];
        end
    end

endmodule

module cmp_serial #(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 8,
    parameter int EARLY_EXIT = 1,
    parameter int SPEED      = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             gt_o,
    output logic             eq_o,
    output logic             lt_o,
    output logic             ge_o
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("cmp_serial: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("cmp_serial: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    logic [WIDTH-1:0] a_bias;
    logic [WIDTH-1:0] b_bias;
    assign a_bias = a_q ^ {sgn_q, {(WIDTH-1){1'b0}}};
    assign b_bias = b_q ^ {sgn_q, {(WIDTH-1){1'b0}}};

    logic [N-1:0][DIGIT-1:0] a_dig;
    logic [N-1:0][DIGIT-1:0] b_dig;
    assign a_dig = a_bias;
    assign b_dig = b_bias;

    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    assign da = a_dig[idx_q];
    assign db = b_dig[idx_q];

    logic dig_ge;
    logic dig_eq;
    logic dig_gt;

    cmp_ge #(
        .WIDTH (DIGIT),
        .SPEED (SPEED)
    ) u_ge (
        .a_i  (da),
        .b_i  (db),
        .ge_o (dig_ge)
    );

    assign dig_eq = (da == db);
    assign dig_gt = dig_ge & ~dig_eq;

    logic decided;
    logic hit;
    assign decided = gt_q | lt_q;
    assign hit     = ~decided & ~dig_eq;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    sgn_d   = signed_i;
                    idx_d   = IW'(N - 1);
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (hit) begin
                    gt_d = dig_gt;
                    lt_d = ~dig_gt;
                end
                if (idx_q == '0 || (EARLY_EXIT != 0 && hit)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign gt_o    = valid_o & gt_q;
    assign lt_o    = valid_o & lt_q;
    assign eq_o    = valid_o & ~decided;
    assign ge_o    = valid_o & ~lt_q;

endmodule
